physical_transmitter: RTL

// QPSK framing transmitter: the TX end of the symbol link whose RX end is physical_receiver.

---
 rtl/physical_transmitter_if.sv | 26 ++
 rtl/physical_transmitter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/physical_transmitter_if.sv
// physical_transmitter_if: handshake bundle for the QPSK framing transmitter.
//   in_valid/in_data/in_ready      : 2-bit Gray-coded payload symbol stream into the TX
//   out_valid/out_data/out_ready   : {I[11:0],Q[11:0]} sample stream towards the DAC/DMA
//   underrun                       : one-cycle pulse when a payload slot is padded
//   tx_busy                        : frame (SOF or payload) in progress
// master: the side feeding symbols and consuming samples; slave: the transmitter.
interface physical_transmitter_if;
  logic        in_valid;
  logic [1:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [23:0] out_data;
  logic        out_ready;
  logic        underrun;
  logic        tx_busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, underrun, tx_busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, underrun, tx_busy
  );
endinterface

// File: rtl/physical_transmitter.sv
// physical_transmitter: QPSK framing transmitter (TX end of the physical_receiver link).
// Prepends a 26-symbol SOF preamble to every PAYLOAD_LEN-symbol frame, maps each
// 2-bit symbol to signed 12-bit I/Q (+/-AMP) and holds it for SPS samples.
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset (aborts any frame in progress)
//   bus        physical_transmitter_if.slave: symbol input, sample output,
//              underrun pulse and tx_busy status
// Optional feature: define PHY_TX_IDLE_FILL_EN to emit alternating 00/11 fill
// symbols while idle instead of holding out_valid low.
module physical_transmitter #(
  parameter int unsigned        SPS         = 8,
  parameter int unsigned        PAYLOAD_LEN = 63,
  parameter logic signed [11:0] AMP         = 12'sd400
) (
  input  logic                  clk,
  input  logic                  rst,
  physical_transmitter_if.slave bus
);

  localparam int unsigned        CW          = $clog2(SPS);
  localparam logic [CW-1:0]      LAST_SAMPLE = CW'(SPS - 1);
  localparam logic [6:0]         SOF_LAST    = 7'd25;
  localparam logic [6:0]         PAY_LAST    = 7'(PAYLOAD_LEN - 1);
  localparam logic [31:0]        SOF_I       = 32'h0327_8428;
  localparam logic [31:0]        SOF_Q       = 32'h0272_d17d;
  localparam logic signed [11:0] AMP_NEG     = -AMP;

  typedef enum logic [1:0] {IDLE, SOF, PAYLOAD} state_t;

  state_t        state, state_n;
  logic          buf_full, buf_full_n;
  logic [1:0]    buf_data, buf_data_n;
  logic [1:0]    cur_sym, cur_sym_n;
  logic [CW-1:0] sample_cnt, sample_cnt_n;
  logic [6:0]    sym_cnt, sym_cnt_n;
  logic          underrun_q, underrun_n;
`ifdef PHY_TX_IDLE_FILL_EN
  logic          fill_phase, fill_phase_n;
`endif

  logic       xfer, last, load, fetch, pop;
  logic       valid;
  logic [1:0] neg;
  logic [4:0] sof_idx;

  // Next-state: frame sequencing, symbol buffer and payload fetch
  always_comb begin
    state_n      = state;
    sample_cnt_n = sample_cnt;
    sym_cnt_n    = sym_cnt;
    cur_sym_n    = cur_sym;
    underrun_n   = 1'b0;
    fetch        = 1'b0;
`ifdef PHY_TX_IDLE_FILL_EN
    fill_phase_n = fill_phase;
`endif
    xfer = bus.out_valid & bus.out_ready;
    last = (sample_cnt == LAST_SAMPLE);
    load = bus.in_valid & bus.in_ready;

    if (xfer) sample_cnt_n = last ? '0 : sample_cnt + CW'(1);

    case (state)
      IDLE: begin
`ifdef PHY_TX_IDLE_FILL_EN
        // Leave for SOF only on a fill-symbol boundary so the RX never sees a short symbol
        if (xfer && last) begin
          fill_phase_n = ~fill_phase;
          if (buf_full) begin
            state_n      = SOF;
            sym_cnt_n    = '0;
            fill_phase_n = 1'b0;
          end
        end
`else
        if (buf_full) begin
          state_n      = SOF;
          sym_cnt_n    = '0;
          sample_cnt_n = '0;
        end
`endif
      end
      SOF: begin
        if (xfer && last) begin
          if (sym_cnt == SOF_LAST) begin
            state_n   = PAYLOAD;
            sym_cnt_n = '0;
            fetch     = 1'b1;
          end else begin
            sym_cnt_n = sym_cnt + 7'd1;
          end
        end
      end
      PAYLOAD: begin
        if (xfer && last) begin
          if (sym_cnt == PAY_LAST) begin
            sym_cnt_n = '0;
            state_n   = buf_full ? SOF : IDLE;
          end else begin
            sym_cnt_n = sym_cnt + 7'd1;
            fetch     = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (fetch) begin
      if (buf_full) begin
        cur_sym_n = buf_data;
      end else begin
        cur_sym_n  = '0;
        underrun_n = 1'b1;
      end
    end

    // A pop and a load in the same cycle leave the buffer full with the new symbol
    pop        = fetch & buf_full;
    buf_full_n = load | (buf_full & ~pop);
    buf_data_n = load ? bus.in_data : buf_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      buf_full   <= 1'b0;
      buf_data   <= '0;
      cur_sym    <= '0;
      sample_cnt <= '0;
      sym_cnt    <= '0;
      underrun_q <= 1'b0;
`ifdef PHY_TX_IDLE_FILL_EN
      fill_phase <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      buf_full   <= buf_full_n;
      buf_data   <= buf_data_n;
      cur_sym    <= cur_sym_n;
      sample_cnt <= sample_cnt_n;
      sym_cnt    <= sym_cnt_n;
      underrun_q <= underrun_n;
`ifdef PHY_TX_IDLE_FILL_EN
      fill_phase <= fill_phase_n;
`endif
    end
  end

  // Output mapping: neg[1] selects -AMP for I, neg[0] for Q
  always_comb begin
    valid   = 1'b0;
    neg     = 2'b00;
    sof_idx = 5'(SOF_LAST - sym_cnt);
    case (state)
      IDLE: begin
`ifdef PHY_TX_IDLE_FILL_EN
        valid = 1'b1;
        neg   = {2{fill_phase}};
`endif
      end
      SOF: begin
        valid = 1'b1;
        neg   = {~SOF_I[sof_idx], ~SOF_Q[sof_idx]};
      end
      PAYLOAD: begin
        valid = 1'b1;
        neg   = cur_sym;
      end
      default: ;
    endcase
  end

  assign bus.out_valid = valid & ~rst;
  assign bus.out_data  = valid ? {neg[1] ? AMP_NEG : AMP, neg[0] ? AMP_NEG : AMP} : '0;
  assign bus.in_ready  = ~buf_full & ~rst;
  assign bus.tx_busy   = (state != IDLE);
  assign bus.underrun  = underrun_q;

endmodule
